// File: rtl/phys_free_list_pkg.sv
// Shared physical-register definitions used by rename, dispatch, complete and the free list.
package phys_free_list_pkg;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PREG_W    = 6;

  typedef logic [PREG_W-1:0] preg_t;

  // Number of asserted bits in a two-lane request/accept pair.
  function automatic logic [1:0] pair_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/phys_free_list.sv
// Circular FIFO of free physical register indices: two show-ahead allocations
// and two returns per cycle, allocation order equal to free order.
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int NUM_PREGS = phys_free_list_pkg::NUM_PREGS,
  parameter int NUM_AREGS = phys_free_list_pkg::NUM_AREGS,
  parameter int PREG_W    = phys_free_list_pkg::PREG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req_1,
  input  logic              alloc_req_2,
  output logic              alloc_grant,
  output logic [PREG_W-1:0] alloc_preg_1,
  output logic [PREG_W-1:0] alloc_preg_2,
  input  logic              free_flag_1,
  input  logic [PREG_W-1:0] free_preg_1,
  input  logic              free_flag_2,
  input  logic [PREG_W-1:0] free_preg_2,
  output logic [PREG_W:0]   free_count,
  output logic              empty,
  output logic              overflow_err
);

  logic [PREG_W-1:0] list [NUM_PREGS];
  logic [PREG_W-1:0] head;
  logic [PREG_W-1:0] tail;
  logic [PREG_W:0]   count;

  logic [1:0]        n_req;
  logic [1:0]        n_alloc;
  logic [1:0]        n_free;
  logic [PREG_W-1:0] head_plus1;
  logic [PREG_W-1:0] tail_wr2;
  logic [PREG_W+1:0] room;
  logic              dup;
  logic              acc_1;
  logic              acc_2;
  logic              drop;

  // Allocation is judged only against the registered count: frees landing
  // this edge are never visible to this cycle's requests.
  assign n_req        = pair_count(alloc_req_1, alloc_req_2);
  assign alloc_grant  = count >= {{(PREG_W-1){1'b0}}, n_req};
  assign n_alloc      = alloc_grant ? n_req : 2'd0;
  assign head_plus1   = head + PREG_W'(1);
  assign alloc_preg_1 = list[head];
  assign alloc_preg_2 = alloc_req_1 ? list[head_plus1] : list[head];

  // Capacity left once this cycle's granted allocations have drained.
  assign room  = (PREG_W+2)'(NUM_PREGS)
               - ({1'b0, count} - {{PREG_W{1'b0}}, n_alloc});
  assign dup   = free_flag_1 && free_flag_2 && (free_preg_1 == free_preg_2);
  assign acc_1 = free_flag_1 && (room != '0);
  assign acc_2 = free_flag_2 && !dup && (room > {{(PREG_W+1){1'b0}}, acc_1});
  assign drop  = (free_flag_1 && !acc_1) || (free_flag_2 && !acc_2);

  assign n_free   = pair_count(acc_1, acc_2);
  assign tail_wr2 = acc_1 ? tail + PREG_W'(1) : tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= PREG_W'(NUM_AREGS);
      count        <= (PREG_W+1)'(NUM_AREGS);
      overflow_err <= 1'b0;
    end else begin
      head  <= head + {{(PREG_W-2){1'b0}}, n_alloc};
      tail  <= tail + {{(PREG_W-2){1'b0}}, n_free};
      count <= count - {{(PREG_W-1){1'b0}}, n_alloc}
                     + {{(PREG_W-1){1'b0}}, n_free};
      if (drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Upper registers start free; the lower ones back the reset RAT mapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        list[i] <= (i < NUM_AREGS) ? PREG_W'(NUM_AREGS + i) : '0;
      end
    end else begin
      if (acc_1) begin
        list[tail] <= free_preg_1;
      end
      if (acc_2) begin
        list[tail_wr2] <= free_preg_2;
      end
    end
  end

  assign free_count = count;
  assign empty      = (count == '0);

endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: queue-based reference model checked every cycle plus literal expectations.
module tb_phys_free_list;
  import phys_free_list_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  a1 = 1'b0, a2 = 1'b0, f1 = 1'b0, f2 = 1'b0;
  preg_t p1 = '0, p2 = '0;
  logic  alloc_grant, empty, overflow_err;
  preg_t alloc_preg_1, alloc_preg_2;
  logic [PREG_W:0] free_count;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Reference model: queue of free registers in allocation order.
  int q[$];
  int held[$];
  bit m_ovf;
  int mn;

  phys_free_list dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req_1(a1), .alloc_req_2(a2), .alloc_grant(alloc_grant),
    .alloc_preg_1(alloc_preg_1), .alloc_preg_2(alloc_preg_2),
    .free_flag_1(f1), .free_preg_1(p1), .free_flag_2(f2), .free_preg_2(p2),
    .free_count(free_count), .empty(empty), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    held.delete();
    for (int i = 0; i < NUM_AREGS; i++) q.push_back(NUM_AREGS + i);
    m_ovf = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      mn = int'(a1) + int'(a2);
      if (q.size() >= mn) begin
        repeat (mn) held.push_back(q.pop_front());
      end
      if (f1) begin
        if (q.size() < NUM_PREGS) q.push_back(int'(p1));
        else m_ovf = 1'b1;
      end
      if (f2) begin
        if (f1 && p1 == p2) m_ovf = 1'b1;
        else if (q.size() < NUM_PREGS) q.push_back(int'(p2));
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      int n;
      bit eg;
      n  = int'(a1) + int'(a2);
      eg = q.size() >= n;
      chk("grant", int'(alloc_grant), int'(eg));
      if (eg && a1) chk("preg1", int'(alloc_preg_1), q[0]);
      if (eg && a2) chk("preg2", int'(alloc_preg_2), a1 ? q[1] : q[0]);
      chk("free_count", int'(free_count), q.size());
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("overflow_err", int'(overflow_err), int'(m_ovf));
    end
  end

  task automatic drive(input bit r1, input bit r2, input bit ff1, input int pp1,
                       input bit ff2, input int pp2);
    a1 = r1; a2 = r2; f1 = ff1; f2 = ff2;
    p1 = preg_t'(pp1); p2 = preg_t'(pp2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int k;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(free_count), 32);
    chk("rst_empty", int'(empty), 0);
    chk("rst_ovf", int'(overflow_err), 0);
    chk("rst_preg1", int'(alloc_preg_1), 32);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Drain the pool two at a time.
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      #1;
      chk("burst_grant", int'(alloc_grant), 1);
      chk("burst_preg1", int'(alloc_preg_1), 32 + 2 * i);
      chk("burst_preg2", int'(alloc_preg_2), 33 + 2 * i);
      chk("burst_count", int'(free_count), 32 - 2 * i);
      tick();
    end
    chk("drained_count", int'(free_count), 0);
    chk("drained_empty", int'(empty), 1);
    drive(1, 1, 0, 0, 0, 0);
    #1;
    chk("empty_grant", int'(alloc_grant), 0);
    tick();
    chk("empty_hold", int'(free_count), 0);

    // Two frees from empty, then single-slot allocations.
    drive(0, 0, 1, 5, 1, 9);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("p5_grant", int'(alloc_grant), 1);
    chk("p5_preg1", int'(alloc_preg_1), 5);
    chk("p5_count", int'(free_count), 2);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    #1;
    chk("p9_grant", int'(alloc_grant), 1);
    chk("p9_preg2", int'(alloc_preg_2), 9);
    tick();
    chk("p9_count", int'(free_count), 0);

    // Allocation sees only the pre-edge count.
    drive(1, 0, 1, 7, 1, 8);
    #1;
    chk("nobypass_grant", int'(alloc_grant), 0);
    tick();
    chk("nobypass_count", int'(free_count), 2);
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("p7_preg1", int'(alloc_preg_1), 7);
    tick();
    chk("one_count", int'(free_count), 1);

    // All-or-nothing with one register left.
    drive(1, 1, 0, 0, 0, 0);
    #1;
    chk("partial_grant", int'(alloc_grant), 0);
    tick();
    chk("partial_count", int'(free_count), 1);
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("partial_head", int'(alloc_preg_1), 8);
    tick();
    drive(0, 0, 0, 0, 0, 0);

    // Fill to capacity, then one free too many.
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 2 * i, 1, 2 * i + 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("full_count", int'(free_count), 64);
    chk("full_ovf", int'(overflow_err), 0);
    drive(0, 0, 1, 40, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("over_ovf", int'(overflow_err), 1);
    chk("over_count", int'(free_count), 64);

    // Mixed traffic, wrapping both pointers.
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      bit r1, r2, ff1, ff2;
      int v1, v2;
      r1 = (i % 3) != 0;
      r2 = (i % 4) == 1 || (i % 7) == 3;
      ff1 = 0; ff2 = 0; v1 = 0; v2 = 0;
      if (held.size() > 0 && ((i % 2) == 0 || held.size() > 6)) begin
        ff1 = 1; v1 = held.pop_front();
      end
      if (held.size() > 0 && (i % 5) == 1) begin
        ff2 = 1; v2 = held.pop_front();
      end
      drive(r1, r2, ff1, v1, ff2, v2);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("mix_ovf", int'(overflow_err), 0);

    // Duplicate return sets the sticky error, then async reset mid-burst.
    apply_reset();
    drive(0, 0, 1, 3, 1, 3);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("dup_count", int'(free_count), 33);
    chk("dup_ovf", int'(overflow_err), 1);
    drive(1, 1, 0, 0, 0, 0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_count", int'(free_count), 32);
    chk("arst_preg1", int'(alloc_preg_1), 32);
    chk("arst_preg2", int'(alloc_preg_2), 33);
    chk("arst_empty", int'(empty), 0);
    chk("arst_ovf", int'(overflow_err), 0);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_preg1", int'(alloc_preg_1), 32);
    tick();
    chk("post_rst_count", int'(free_count), 31);
    k = int'(alloc_preg_1);
    chk("post_rst_next", k, 33);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
